// File: rtl/matmul_stream_ctrl_pkg.sv
// Shared definitions for the matmul stream controller: FSM state encoding and
// the row-major, MSB-first element placement used on every flat matrix bus.
package matmul_stream_ctrl_pkg;

  typedef enum logic [2:0] {
    S_LOAD_A = 3'd0,
    S_LOAD_B = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_UNLOAD = 3'd4
  } state_t;

  // LSB position of flat row-major element k (k = i*w + j) in an n-element bus
  // of s-bit elements; element 0 sits in the MSBs.
  function automatic int elem_lsb(input int k, input int n, input int s);
    return s * (n - 1 - k);
  endfunction

  // Counter width able to hold max_count without wrapping.
  function automatic int ctr_width(input int max_count);
    return $clog2(max_count) + 1;
  endfunction

endpackage

// File: rtl/matmul_stream_ctrl_mm_elem_serializer.sv
// Holds a captured H*W result bus and presents it one element at a time on a
// valid/ready stream, row-major, with last on the final element.
module mm_elem_serializer
  import matmul_stream_ctrl_pkg::*;
#(
  parameter int S = 32,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [S*N-1:0] res_in,
  input  logic           out_ready,
  output logic           out_valid,
  output logic [S-1:0]   out_data,
  output logic           out_last
);

  localparam int OW = ctr_width(N);

  logic [S*N-1:0] result_reg;
  logic [OW-1:0]  oidx_reg;
  logic           valid_reg;
  logic [S-1:0]   elem [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_elem
    localparam int LSB = elem_lsb(gi, N, S);
    assign elem[gi] = result_reg[LSB +: S];
  end

  assign out_valid = valid_reg;
  assign out_last  = valid_reg && (oidx_reg == OW'(N - 1));

  // Select the current element; it only moves when oidx advances, so the data
  // stays stable while the consumer stalls.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < N; k++) begin
      if (oidx_reg == OW'(k)) out_data = elem[k];
    end
  end

  // Capture the result on load, then step through it on each accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= '0;
      oidx_reg   <= '0;
      valid_reg  <= 1'b0;
    end else if (load) begin
      result_reg <= res_in;
      oidx_reg   <= '0;
      valid_reg  <= 1'b1;
    end else if (valid_reg && out_ready) begin
      if (oidx_reg == OW'(N - 1)) begin
        valid_reg <= 1'b0;
        oidx_reg  <= '0;
      end else begin
        oidx_reg <= oidx_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/matmul_stream_ctrl.sv
// Host-side driver for the flat-bus matmul: gathers A then B element-by-element,
// pulses start, waits for a fresh done and streams the result back out.
module matmul_stream_ctrl
  import matmul_stream_ctrl_pkg::*;
#(
  parameter int S       = 32,
  parameter int H       = 2,
  parameter int W       = 2,
  parameter int C       = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [S-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [S-1:0]     out_data,
  output logic             out_last,
  output logic             mm_start,
  output logic [S*H*C-1:0] mm_a,
  output logic [S*C*W-1:0] mm_b,
  input  logic [S*H*W-1:0] mm_o,
  input  logic             mm_done,
  output logic             busy,
  output logic             err
);

  localparam int NA = H * C;
  localparam int NB = C * W;
  localparam int NO = H * W;
  localparam int IW = ctr_width((NA > NB) ? NA : NB);
  localparam int TW = ctr_width((TIMEOUT > 1) ? TIMEOUT : 2);

  state_t        state_reg;
  logic [IW-1:0] idx_reg;
  logic [TW-1:0] tcnt_reg;
  logic          armed_reg;
  logic          err_reg;
  logic          mm_start_reg;
  logic [S-1:0]  a_reg [NA];
  logic [S-1:0]  b_reg [NB];
  logic          xfer;
  logic          capture;
  logic          unload_done;

  // Gated by rst_n so nothing is offered while the block is held in reset.
  assign in_ready    = rst_n && (state_reg == S_LOAD_A || state_reg == S_LOAD_B);
  assign xfer        = in_valid && in_ready;
  assign capture     = (state_reg == S_WAIT) && armed_reg && mm_done;
  assign unload_done = out_valid && out_ready && out_last;
  assign busy        = !(state_reg == S_LOAD_A && idx_reg == '0);
  assign mm_start    = mm_start_reg;
  assign err         = err_reg;

  for (genvar gi = 0; gi < NA; gi++) begin : g_pack_a
    localparam int LSB = elem_lsb(gi, NA, S);
    assign mm_a[LSB +: S] = a_reg[gi];
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_pack_b
    localparam int LSB = elem_lsb(gi, NB, S);
    assign mm_b[LSB +: S] = b_reg[gi];
  end

  // Operand storage: accepted elements land at the current load index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NA; k++) a_reg[k] <= '0;
      for (int k = 0; k < NB; k++) b_reg[k] <= '0;
    end else if (xfer) begin
      for (int k = 0; k < NA; k++) begin
        if (state_reg == S_LOAD_A && idx_reg == IW'(k)) a_reg[k] <= in_data;
      end
      for (int k = 0; k < NB; k++) begin
        if (state_reg == S_LOAD_B && idx_reg == IW'(k)) b_reg[k] <= in_data;
      end
    end
  end

  // Control FSM: load A, load B, start pulse, wait for a fresh done, unload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_LOAD_A;
      idx_reg      <= '0;
      tcnt_reg     <= '0;
      armed_reg    <= 1'b0;
      err_reg      <= 1'b0;
      mm_start_reg <= 1'b0;
    end else begin
      mm_start_reg <= 1'b0;
      case (state_reg)
        S_LOAD_A: begin
          if (xfer) begin
            err_reg <= 1'b0;
            if (idx_reg == IW'(NA - 1)) begin
              idx_reg   <= '0;
              state_reg <= S_LOAD_B;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end
        S_LOAD_B: begin
          if (xfer) begin
            if (idx_reg == IW'(NB - 1)) begin
              idx_reg      <= '0;
              state_reg    <= S_START;
              mm_start_reg <= 1'b1;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end
        S_START: begin
          armed_reg <= 1'b0;
          tcnt_reg  <= '0;
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (armed_reg && mm_done) begin
            state_reg <= S_UNLOAD;
          end else begin
            // A done seen before it has ever gone low belongs to an older job.
            if (!mm_done) armed_reg <= 1'b1;
            if (TIMEOUT != 0 && tcnt_reg == TW'(TIMEOUT - 1)) begin
              err_reg   <= 1'b1;
              idx_reg   <= '0;
              state_reg <= S_LOAD_A;
            end else begin
              tcnt_reg <= tcnt_reg + 1'b1;
            end
          end
        end
        S_UNLOAD: begin
          if (unload_done) state_reg <= S_LOAD_A;
        end
        default: state_reg <= S_LOAD_A;
      endcase
    end
  end

  mm_elem_serializer #(
    .S(S),
    .N(NO)
  ) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (capture),
    .res_in   (mm_o),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last)
  );

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// Randomized bench for matmul_stream_ctrl with a stub matmul responder and a
// queue/array-level model of what the operand buses and result stream must be.
module tb_matmul_stream_ctrl;

  localparam int S  = 32;
  localparam int NA = 4;
  localparam int NB = 4;
  localparam int NO = 4;
  localparam int BA = S * NA;
  localparam int BB = S * NB;
  localparam int BO = S * NO;
  localparam int R_NORMAL = 0;
  localparam int R_STALE  = 1;
  localparam int R_SILENT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [S-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [S-1:0]  out_data;
  logic          out_last;
  logic          mm_start;
  logic [BA-1:0] mm_a;
  logic [BB-1:0] mm_b;
  logic [BO-1:0] mm_o = '0;
  logic          mm_done = 1'b0;
  logic          busy;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;
  int start_cnt = 0;
  int rcnt = 0;
  int resp_mode = R_NORMAL;
  int resp_delay = 5;
  int op_num = 0;
  bit err_pending = 1'b0;
  logic [BO-1:0] resp_bus = '0;
  logic [BA-1:0] exp_a;
  logic [BB-1:0] exp_b;
  logic [S-1:0]  op_a [NA];
  logic [S-1:0]  op_b [NB];
  logic [S-1:0]  res  [NO];

  matmul_stream_ctrl #(.S(S), .H(2), .W(2), .C(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .mm_start(mm_start),
    .mm_a(mm_a), .mm_b(mm_b), .mm_o(mm_o), .mm_done(mm_done),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Count start pulses, one per cycle in which mm_start is high.
  always @(negedge clk) if (mm_start) start_cnt <= start_cnt + 1;

  // Stub matmul: normal answers resp_delay cycles after start; stale keeps an
  // old done high, drops it once, then answers; silent never answers.
  always @(negedge clk) begin
    if (mm_start) begin
      rcnt <= 1;
      if (resp_mode != R_STALE) mm_done <= 1'b0;
    end else if (rcnt != 0) begin
      rcnt <= (rcnt >= 100) ? 0 : rcnt + 1;
      if (resp_mode == R_NORMAL && rcnt == resp_delay) begin
        mm_done <= 1'b1; mm_o <= resp_bus; rcnt <= 0;
      end
      if (resp_mode == R_STALE && rcnt == 3) mm_done <= 1'b0;
      if (resp_mode == R_STALE && rcnt == 4) begin
        mm_done <= 1'b1; mm_o <= resp_bus; rcnt <= 0;
      end
    end else if (resp_mode == R_STALE) begin
      mm_done <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pack the expected result row-major, first element in the MSBs.
  task automatic build_resp();
    resp_bus = '0;
    for (int k = 0; k < NO; k++) resp_bus = (resp_bus << S) | BO'(res[k]);
  endtask

  task automatic random_ops();
    for (int k = 0; k < NA; k++) op_a[k] = $urandom;
    for (int k = 0; k < NB; k++) op_b[k] = $urandom;
    for (int k = 0; k < NO; k++) res[k] = $urandom;
    build_resp();
  endtask

  // Feed A then B; returns at the negedge of the start cycle.
  task automatic load_ops(input bit gaps);
    int g;
    exp_a = '0;
    exp_b = '0;
    for (int k = 0; k < NA + NB; k++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        for (int q = 0; q < g; q++) begin
          in_valid = 1'b0; in_data = $urandom; @(negedge clk);
        end
      end
      if (k == 0) begin
        check("busy_idle", busy, 0);
        if (err_pending) check("err_sticky", err, 1);
      end
      if (k == 1) begin
        check("busy_load", busy, 1);
        check("err_clear", err, 0);
        err_pending = 1'b0;
      end
      in_valid = 1'b1;
      if (k < NA) begin
        in_data = op_a[k]; exp_a = (exp_a << S) | BA'(op_a[k]);
      end else begin
        in_data = op_b[k-NA]; exp_b = (exp_b << S) | BB'(op_b[k-NA]);
      end
      check("in_ready_load", in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("start_pulse", mm_start, 1);
    check("start_in_ready", in_ready, 0);
    check("mm_a", mm_a, exp_a);
    check("mm_b", mm_b, exp_b);
  endtask

  task automatic run_op(input bit gaps, input int bp, input bit reject, input int abort_after);
    int start_before, cyc, first, n, exp_lat;
    bit rdy, pv, pr;
    logic [S-1:0] pd;
    start_before = start_cnt;
    load_ops(gaps);
    if (reject) begin in_valid = 1'b1; in_data = $urandom; end
    exp_lat = (resp_mode == R_STALE) ? 5 : resp_delay + 1;
    cyc = 0; first = 0;
    while (first == 0 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (out_valid) first = cyc;
      else if (reject) check("wait_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    check("start_count", start_cnt - start_before, 1);
    if (first == 0) begin
      check("out_valid_seen", out_valid, 1);
      return;
    end
    check("first_valid_latency", first, exp_lat);
    check("mm_a_hold", mm_a, exp_a);
    check("mm_b_hold", mm_b, exp_b);
    n = 0; cyc = 0; pv = 1'b0; pr = 1'b0; pd = '0;
    while (n < NO && cyc < 200) begin
      if (cyc > 0) @(negedge clk);
      if (abort_after != 0 && n == abort_after) begin
        out_ready = 1'b0; rst_n = 1'b0; #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_out_last", out_last, 0);
        check("rst_mm_a", mm_a, 0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        $display("op %0d: reset after %0d of %0d results", op_num, n, NO);
        op_num++;
        return;
      end
      if (pv && !pr) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, pd);
      end
      case (bp)
        0: rdy = 1'b1;
        1: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      cyc++;
      out_ready = rdy;
      if (out_valid) begin
        check("out_data", out_data, res[n]);
        check("out_last", out_last, (n == NO - 1));
        if (rdy) n++;
      end
      pv = out_valid; pr = rdy; pd = out_data;
    end
    @(negedge clk);
    out_ready = 1'b0;
    check("results_delivered", n, NO);
    check("idle_out_valid", out_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_in_ready", in_ready, 1);
    $display("op %0d: mode=%0d delay=%0d gaps=%0d bp=%0d reject=%0d latency=%0d results=%0d",
             op_num, resp_mode, resp_delay, gaps, bp, reject, first, n);
    op_num++;
  endtask

  task automatic run_timeout();
    resp_mode = R_SILENT;
    random_ops();
    load_ops(1'b0);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c <= 16) check("timeout_in_ready", in_ready, 0);
      if (c == 16) check("err_before_timeout", err, 0);
    end
    check("err_timeout", err, 1);
    check("timeout_in_ready_back", in_ready, 1);
    check("timeout_busy", busy, 0);
    check("timeout_out_valid", out_valid, 0);
    err_pending = 1'b1;
    repeat (2) @(negedge clk);
    $display("op %0d: timeout, err=%0b", op_num, err);
    op_num++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    check("reset_mm_start", mm_start, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_last", out_last, 0);
    check("reset_out_data", out_data, 0);
    check("reset_mm_a", mm_a, 0);
    check("reset_mm_b", mm_b, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release_in_ready", in_ready, 1);

    // Basic run: A = 1,2,3,4 as floats, B = identity, result echoes A.
    op_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    op_b = '{32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000};
    res  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    build_resp();
    resp_mode = R_NORMAL; resp_delay = 5;
    run_op(1'b0, 0, 1'b0, 0);

    resp_mode = R_STALE; random_ops();
    run_op(1'b0, 0, 1'b0, 0);

    resp_mode = R_NORMAL; resp_delay = 3; random_ops();
    run_op(1'b0, 1, 1'b0, 0);

    resp_delay = 7; random_ops();
    run_op(1'b1, 0, 1'b1, 0);

    run_timeout();

    resp_mode = R_NORMAL; resp_delay = 4; random_ops();
    run_op(1'b1, 2, 1'b0, 0);

    random_ops();
    run_op(1'b0, 0, 1'b0, 2);

    random_ops();
    run_op(1'b0, 1, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      resp_mode  = ($urandom_range(0, 3) == 0) ? R_STALE : R_NORMAL;
      resp_delay = $urandom_range(2, 10);
      random_ops();
      run_op(1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/matmul_stream_ctrl.md
Name: matmul_stream_ctrl

Overview:
- Host-side driver for the flat-bus matmul block (start/done, packed row-major operands).
- Accepts operand elements one at a time over a valid/ready stream and packs them into the A (H×C) and B (C×W) buses.
- Pulses start, waits for done, captures the H×W result, and streams it out element by element over a second valid/ready stream.
- Lets upstream layers feed the matmul without building S·H·C-wide buses themselves.

Parameters:
- S, 32, element width in bits (IEEE single by default; the block never interprets the value).
- H, 2, rows of A and of the result.
- W, 2, columns of B and of the result.
- C, 2, common dimension.
- TIMEOUT, 1024, maximum WAIT cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  S  operand element.
- out_valid  out  1  result element valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  S  result element.
- out_last  out  1  high with the final (H·W-th) result element.
- mm_start  out  1  one-cycle start pulse to the matmul.
- mm_a  out  S·H·C  packed A operand.
- mm_b  out  S·C·W  packed B operand.
- mm_o  in  S·H·W  matmul result bus.
- mm_done  in  1  matmul done (level).
- busy  out  1  high in every state except LOAD_A with zero elements accepted.
- err  out  1  sticky timeout flag.

Behaviour:
- Clocking/reset: one clock domain; reset is asynchronous, active-low. On reset:
  - state=LOAD_A; counters=0.
  - mm_a, mm_b, result register all 0.
  - mm_start, out_valid, out_last, err, busy all 0; in_ready=1 once reset is released.
- Packing: element (i,j) of an h×w matrix occupies bits [S·(h·w−(i·w+j))−1 : S·(h·w−(i·w+j)−1)], so element (0,0) is in the MSBs. The same rule is used for mm_a, mm_b and mm_o.
- Input order: H·C elements of A in row-major order, then C·W elements of B in row-major order. A transfer occurs when in_valid && in_ready.
- State machine:
  - LOAD_A: in_ready=1. Each transfer writes A element idx and increments idx. After element H·C−1, idx←0 and go to LOAD_B.
  - LOAD_B: in_ready=1, same as LOAD_A for C·W elements. After the last element, go to START.
  - START: in_ready=0; mm_start=1 for exactly this one cycle; armed←0; tcnt←0. Go to WAIT.
  - WAIT:
    - in_ready=0; mm_a and mm_b are held stable.
    - mm_done is ignored until it has been sampled low at least once after START (armed←1). This rejects a stale done left over from a previous operation.
    - When armed && mm_done: latch mm_o into the result register, oidx←0, go to UNLOAD.
    - If TIMEOUT≠0 and tcnt reaches TIMEOUT−1 without completion: err←1, go to LOAD_A, and discard the operands (registers keep their values but are overwritten on the next load).
  - UNLOAD:
    - out_valid=1; out_data=result element oidx in row-major order; out_last=(oidx==H·W−1).
    - On out_ready: oidx++. After the last element, go to LOAD_A.
    - out_data must stay stable while out_valid && !out_ready.
- Latency:
  - mm_start is asserted one cycle after the last B element is accepted.
  - The first out_valid appears one cycle after the clock edge where armed && mm_done is sampled.
- err clears on the first accepted element of the next LOAD_A. When the clearing condition and the setting condition are simultaneous, set wins (this cannot occur, by the state structure).
- in_valid during START, WAIT or UNLOAD is not accepted (in_ready=0); no element is lost or duplicated.
- Asserting rst_n low mid-operation (any state) returns the block to its reset values immediately.
- Counter widths are $clog2 of the maximum count plus 1, and never wrap within a legal sequence.

Decomposition:
- Shared package/include: the element-index/slice macro (row-major, MSB-first) shared with the matmul; state encodings S_LOAD_A, S_LOAD_B, S_START, S_WAIT, S_UNLOAD.
- One natural sub-module: mm_elem_serializer (result register + oidx + valid/ready/last).

Test Plan:
- Basic run, H=W=C=2, stub responder with done 5 cycles after start and mm_o=0x3F800000_40000000_40400000_40800000:
  - Input: A=1.0,2.0,3.0,4.0 (0x3F800000..0x40800000), B=identity.
  - Check mm_a=0x3F800000_40000000_40400000_40800000 and mm_b=0x3F800000_00000000_00000000_3F800000.
  - Check exactly one mm_start pulse.
  - Output: 4 elements in order 0x3F800000, 0x40000000, 0x40400000, 0x40800000; out_last only on the 4th.
- Stale done: stub holds mm_done=1 through START, drops it for 1 cycle, then raises it after 3 cycles → no output before done falls; result is captured only on the second rise.
- Backpressure: out_ready toggles 1,0,0,1,… → out_data stays stable while stalled; all 4 elements are delivered once each.
- Input gaps plus rejection: in_valid toggling during load; in_valid held high during WAIT → in_ready=0 in WAIT; mm_a/mm_b unchanged.
- Timeout with TIMEOUT=16, stub never raises done → err=1 at cycle 16 of WAIT, state back to LOAD_A with in_ready=1; err clears on the next accepted element.
- Reset mid-UNLOAD after 2 elements → out_valid=0, err=0, busy=0 immediately; a following full run produces correct results.
